param_instruction_cache: RTL and testbench
==========================================

PARAM_INSTRUCTION_CACHE -- requirements
Module: param_instruction_cache

Interface
REQ-001 SHALL have parameter WAYS, default 2, meaning associativity; legal values 1, 2, 4.
REQ-002 SHALL have parameter SETS, default 256, meaning sets per way; power of two, at least 2.
REQ-003 SHALL have parameter LINE_WORDS, default 16, meaning 32-bit words per line; power of two, at least 4.
REQ-004 SHALL have parameter FETCH_WIDTH, default 3, meaning maximum instructions returned per hit; 1..LINE_WORDS.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset; synchronous, active-high.
REQ-007 SHALL have port fetch_req_i, input, 1, meaning a lookup of addr is requested this cycle.
REQ-008 SHALL have port addr, input, 32, meaning the fetch byte address; bits [1:0] are ignored.
REQ-009 SHALL have port flush_i, input, 1, meaning a one-cycle pulse that invalidates all lines.
REQ-010 SHALL have port data, input, 32, meaning the refill word from memory.
REQ-011 SHALL have port data_valid, input, 1, meaning data holds the word for the current req_addr.
REQ-012 SHALL have port req_addr, output, 32, meaning the refill word address.
REQ-013 SHALL have port write, output, 1, meaning the memory write strobe; always 0.
REQ-014 SHALL have port trans, output, 2, meaning 2'b10 while a refill word is outstanding, else 2'b00.
REQ-015 SHALL have port stall_o, output, 1, meaning the fetch must be held.
REQ-016 SHALL have port instrs_valid_o, output, 1, meaning instrs_o and instrs_count_o are valid.
REQ-017 SHALL have port instrs_count_o, output, clog2(FETCH_WIDTH+1), meaning the number of valid words.
REQ-018 SHALL have port instrs_o, output, 32*FETCH_WIDTH, meaning the instructions; word k is at [32k+31:32k], lowest address first.

Function
REQ-019 Address split SHALL be offset = log2(LINE_WORDS*4) bits, index = log2(SETS) bits, tag = remaining upper bits.
REQ-020 State machine SHALL have two states: LOOKUP (the reset state) and REFILL.
REQ-021 In LOOKUP with fetch_req_i=1 and a hit: on the next edge, instrs_valid_o=1, stall_o=0; latency is 1 cycle.
REQ-022 On a hit, instrs_count_o SHALL be min(FETCH_WIDTH, LINE_WORDS - word_offset); instrs_o words at or above that count SHALL be 0.
REQ-023 In LOOKUP with fetch_req_i=0: on the next edge, instrs_valid_o=0; outputs otherwise hold.
REQ-024 On a miss: on the next edge, state=REFILL, stall_o=1, instrs_valid_o=0, req_addr={tag,index,0}, and the victim way is latched.
REQ-025 Victim SHALL be the lowest-numbered invalid way in the set; if none is invalid, the set's round-robin pointer (log2(WAYS) bits).
REQ-026 In REFILL, trans SHALL be 2'b10 each cycle until the word is accepted; a word is accepted when data_valid=1 and trans=2'b10.
REQ-027 On acceptance, the word SHALL be written at word offset req_addr[offset-1:2], req_addr SHALL advance by 4, and trans SHALL be 2'b00 for one cycle.
REQ-028 data_valid SHALL be ignored when trans=2'b00 or in LOOKUP.
REQ-029 On acceptance of the last word: tag is written, valid is set, the set's pointer advances (modulo WAYS) only if a valid way was replaced, state=LOOKUP, stall_o=0.
REQ-030 After REQ-029, a lookup of the same addr SHALL hit on the next cycle.
REQ-031 addr and fetch_req_i SHALL be ignored during REFILL; the refill uses the latched tag and index.
REQ-032 Valid bits SHALL be held in flops; flush_i in LOOKUP SHALL clear all of them on that edge.
REQ-033 A flush_i pulse with fetch_req_i in the same cycle SHALL be treated as a miss.
REQ-034 flush_i during REFILL SHALL be recorded and applied the cycle the refill completes, which also clears the just-filled line.
REQ-035 write SHALL remain 0 at all times.

Reset
REQ-036 rst SHALL take priority over all other inputs.
REQ-037 On rst: state=LOOKUP; req_addr=0, write=0, trans=2'b00, stall_o=0, instrs_valid_o=0, instrs_count_o=0, instrs_o=0; all valid bits, round-robin pointers and pending flush cleared.
REQ-038 rst during REFILL SHALL abort the refill; the partially filled line SHALL stay invalid.
REQ-039 Data and tag arrays SHALL NOT need reset.

Verification
REQ-040 Cold miss at addr 0x0000_1000 (defaults, one-cycle data_valid) -> req_addr 0x1000..0x103C, 16 words, stall_o falls; the next fetch gives count 3 with words 0..2.
REQ-041 Hit at offset 0x38 (defaults) -> count 2, instrs_o[95:64]=0; at 0x3C -> count 1.
REQ-042 Three tags to one set, WAYS=2 -> third fill evicts way 0; pointer=1; first tag misses again.
REQ-043 data_valid held 0 for 5 cycles mid-refill -> trans stays 2'b10, req_addr stable, no write.
REQ-044 flush_i on a cycle of a 16-word refill -> refill completes, then the same addr misses.
REQ-045 rst asserted at word 7 of a refill -> all outputs at reset values next cycle; the same addr misses afterwards.

Source files
------------

// File: rtl/param_instruction_cache.sv
// Parameterised set-associative instruction cache.
//   Lookup: fetch_req_i/addr are looked up; a hit returns up to FETCH_WIDTH
//   words (never crossing the line end) one cycle later on instrs_o /
//   instrs_count_o / instrs_valid_o.
//   Refill: a miss raises stall_o and fetches the whole line one word at a
//   time via req_addr / trans / data / data_valid; write is tied low.
//   flush_i invalidates every line (deferred to refill end while refilling).
// Ports: clk, rst (sync, active-high), fetch_req_i, addr[31:0], flush_i,
//   data[31:0], data_valid | req_addr[31:0], write, trans[1:0], stall_o,
//   instrs_valid_o, instrs_count_o, instrs_o[32*FETCH_WIDTH-1:0].
module param_instruction_cache #(
  parameter int unsigned WAYS        = 2,
  parameter int unsigned SETS        = 256,
  parameter int unsigned LINE_WORDS  = 16,
  parameter int unsigned FETCH_WIDTH = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 fetch_req_i,
  input  logic [31:0]                          addr,
  input  logic                                 flush_i,
  input  logic [31:0]                          data,
  input  logic                                 data_valid,
  output logic [31:0]                          req_addr,
  output logic                                 write,
  output logic [1:0]                           trans,
  output logic                                 stall_o,
  output logic                                 instrs_valid_o,
  output logic [$clog2(FETCH_WIDTH+1)-1:0]     instrs_count_o,
  output logic [32*FETCH_WIDTH-1:0]            instrs_o
);

  localparam int unsigned OFF_W  = $clog2(LINE_WORDS * 4);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = 32 - OFF_W - IDX_W;
  localparam int unsigned WOFF_W = $clog2(LINE_WORDS);
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned CNT_W  = $clog2(FETCH_WIDTH + 1);

  typedef enum logic {LOOKUP, REFILL} state_t;
  state_t state, state_nx;

  logic [31:0]       data_mem [WAYS][SETS][LINE_WORDS];
  logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
  logic [SETS-1:0]   valid_q  [WAYS];
  logic [WAY_W-1:0]  rr_q     [SETS];
  logic [WAY_W-1:0]  victim_q;
  logic              victim_was_valid_q;
  logic              flush_pend_q;

  logic [TAG_W-1:0]  lk_tag;
  logic [IDX_W-1:0]  lk_idx, r_idx;
  logic [WOFF_W-1:0] lk_woff, r_woff;
  logic [TAG_W-1:0]  r_tag;
  logic              unused_addr_bits;

  assign lk_tag  = addr[31 -: TAG_W];
  assign lk_idx  = addr[OFF_W +: IDX_W];
  assign lk_woff = addr[2 +: WOFF_W];
  // the refill line is identified by the latched req_addr, never by addr
  assign r_tag   = req_addr[31 -: TAG_W];
  assign r_idx   = req_addr[OFF_W +: IDX_W];
  assign r_woff  = req_addr[2 +: WOFF_W];
  assign unused_addr_bits = ^addr[1:0];
  assign write   = 1'b0;

  logic                     hit, victim_valid;
  logic [WAY_W-1:0]         hit_way, victim;
  logic [32*FETCH_WIDTH-1:0] hit_words;
  logic [CNT_W-1:0]         hit_cnt;
  int unsigned              avail, cnt_i;
  logic                     found;

  always_comb begin
    hit          = 1'b0;
    hit_way      = '0;
    found        = 1'b0;
    victim       = rr_q[lk_idx];
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[w][lk_idx] && (tag_mem[w][lk_idx] == lk_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!found && !valid_q[w][lk_idx]) begin
        found  = 1'b1;
        victim = WAY_W'(w);
      end
    end
    victim_valid = !found;

    hit_words = '0;
    avail     = LINE_WORDS - 32'(lk_woff);
    cnt_i     = (avail < FETCH_WIDTH) ? avail : FETCH_WIDTH;
    hit_cnt   = CNT_W'(cnt_i);
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      if (k < cnt_i)
        hit_words[32*k +: 32] = data_mem[hit_way][lk_idx][WOFF_W'(32'(lk_woff) + k)];
    end
  end

  logic do_hit, do_miss, accept, last;

  always_comb begin
    state_nx = state;
    do_hit   = 1'b0;
    do_miss  = 1'b0;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      LOOKUP: begin
        if (fetch_req_i) begin
          // a flush in the same cycle wins: the lookup is forced to miss
          if (hit && !flush_i) begin
            do_hit = 1'b1;
          end else begin
            do_miss  = 1'b1;
            state_nx = REFILL;
          end
        end
      end
      REFILL: begin
        if ((trans == 2'b10) && data_valid) begin
          accept = 1'b1;
          if (r_woff == '1) begin
            last     = 1'b1;
            state_nx = LOOKUP;
          end
        end
      end
      default: state_nx = LOOKUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= LOOKUP;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr           <= '0;
      trans              <= 2'b00;
      stall_o            <= 1'b0;
      instrs_valid_o     <= 1'b0;
      instrs_count_o     <= '0;
      instrs_o           <= '0;
      victim_q           <= '0;
      victim_was_valid_q <= 1'b0;
      flush_pend_q       <= 1'b0;
      for (int unsigned w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int unsigned s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (state == LOOKUP) begin
      if (flush_i)
        for (int unsigned w = 0; w < WAYS; w++) valid_q[w] <= '0;
      if (do_hit) begin
        instrs_valid_o <= 1'b1;
        stall_o        <= 1'b0;
        instrs_count_o <= hit_cnt;
        instrs_o       <= hit_words;
      end else if (do_miss) begin
        instrs_valid_o     <= 1'b0;
        stall_o            <= 1'b1;
        req_addr           <= {lk_tag, lk_idx, {OFF_W{1'b0}}};
        trans              <= 2'b10;
        victim_q           <= victim;
        victim_was_valid_q <= victim_valid;
        flush_pend_q       <= 1'b0;
      end else begin
        instrs_valid_o <= 1'b0;
      end
    end else begin
      if (flush_i) flush_pend_q <= 1'b1;
      if (accept) begin
        req_addr <= req_addr + 32'd4;
        trans    <= 2'b00;
        if (last) begin
          stall_o      <= 1'b0;
          flush_pend_q <= 1'b0;
          // a flush seen at any point of the refill also drops the new line
          if (flush_pend_q || flush_i)
            for (int unsigned w = 0; w < WAYS; w++) valid_q[w] <= '0;
          else
            valid_q[victim_q][r_idx] <= 1'b1;
          if (victim_was_valid_q)
            rr_q[r_idx] <= (32'(victim_q) == WAYS - 1) ? '0 : victim_q + 1'b1;
        end
      end else begin
        trans <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      data_mem[victim_q][r_idx][r_woff] <= data;
      if (last) tag_mem[victim_q][r_idx] <= r_tag;
    end
  end

endmodule

// File: tb/tb_param_instruction_cache.sv
module tb_param_instruction_cache;

  logic        clk = 1'b0;
  logic        rst, fetch_req_i, flush_i, data_valid;
  logic [31:0] addr, data, req_addr;
  logic        write, stall_o, instrs_valid_o;
  logic [1:0]  trans;
  logic [1:0]  instrs_count_o;
  logic [95:0] instrs_o;

  param_instruction_cache #(.WAYS(2), .SETS(256), .LINE_WORDS(16), .FETCH_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .fetch_req_i(fetch_req_i), .addr(addr), .flush_i(flush_i),
    .data(data), .data_valid(data_valid), .req_addr(req_addr), .write(write),
    .trans(trans), .stall_o(stall_o), .instrs_valid_o(instrs_valid_o),
    .instrs_count_o(instrs_count_o), .instrs_o(instrs_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference state: per set, which tags are resident and the replacement pointer
  bit          mv  [2][256];
  logic [17:0] mt  [2][256];
  int          mrr [256];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  function automatic logic [95:0] exp_words(input logic [31:0] a, input int cnt);
    logic [95:0] r;
    logic [31:0] b;
    r = '0;
    b = {a[31:2], 2'b00};
    for (int k = 0; k < 3; k++)
      if (k < cnt) r[32*k +: 32] = memf(b + 32'(4 * k));
    return r;
  endfunction

  function automatic int exp_cnt(input logic [31:0] a);
    int left;
    left = 16 - int'(a[5:2]);
    return (left < 3) ? left : 3;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    int idx;
    idx = int'(a[13:6]);
    for (int w = 0; w < 2; w++)
      if (mv[w][idx] && mt[w][idx] == a[31:14]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_clear();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 256; s++) mv[w][s] = 1'b0;
  endtask

  task automatic m_reset();
    m_clear();
    for (int s = 0; s < 256; s++) mrr[s] = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_addr"}, 128'(req_addr), 128'h0);
    chk({tag, "_trans"}, 128'(trans), 128'h0);
    chk({tag, "_stall"}, 128'(stall_o), 128'h0);
    chk({tag, "_valid"}, 128'(instrs_valid_o), 128'h0);
    chk({tag, "_count"}, 128'(instrs_count_o), 128'h0);
    chk({tag, "_instrs"}, 128'(instrs_o), 128'h0);
    chk({tag, "_write"}, 128'(write), 128'h0);
  endtask

  // One fetch; on a miss the whole line is served. flush_req: flush with the
  // request. flush_at/wait_at/abort_at: word index for a mid-refill flush,
  // a 5-cycle data gap, or a reset (-1 = none).
  task automatic do_fetch(input logic [31:0] a, input bit flush_req, input int flush_at,
                          input int wait_at, input int abort_at, output bit dut_missed);
    bit          mhit, vicv, flushed;
    int          idx, vic;
    logic [31:0] base;
    idx  = int'(a[13:6]);
    base = {a[31:6], 6'b0};
    mhit = m_hit(a) && !flush_req;
    vic  = -1;
    for (int w = 0; w < 2; w++)
      if (!mv[w][idx] && vic < 0) vic = w;
    vicv = (vic < 0);
    if (vicv) vic = mrr[idx];
    if (flush_req) m_clear();

    fetch_req_i = 1'b1; addr = a; flush_i = flush_req;
    step();
    fetch_req_i = 1'b0; flush_i = 1'b0; addr = $urandom;
    dut_missed = stall_o;
    chk("write_low", 128'(write), 128'h0);
    if (mhit) begin
      chk("hit_stall", 128'(stall_o), 128'h0);
      chk("hit_valid", 128'(instrs_valid_o), 128'h1);
      chk("hit_count", 128'(instrs_count_o), 128'(exp_cnt(a)));
      chk("hit_instrs", 128'(instrs_o), 128'(exp_words(a, exp_cnt(a))));
      return;
    end
    chk("miss_stall", 128'(stall_o), 128'h1);
    chk("miss_valid", 128'(instrs_valid_o), 128'h0);
    flushed = 1'b0;
    for (int w = 0; w < 16; w++) begin
      if (w == wait_at) begin
        repeat (5) begin
          data_valid = 1'b0;
          step();
          chk("gap_trans", 128'(trans), 128'h2);
          chk("gap_req_addr", 128'(req_addr), 128'(base + 32'(4 * w)));
          chk("gap_write", 128'(write), 128'h0);
        end
      end
      chk("ref_trans", 128'(trans), 128'h2);
      chk("ref_req_addr", 128'(req_addr), 128'(base + 32'(4 * w)));
      if (w == abort_at) begin
        rst = 1'b1; data_valid = 1'b1; data = memf(req_addr);
        step();
        rst = 1'b0; data_valid = 1'b0;
        chk_reset_outputs("abort");
        m_reset();
        return;
      end
      data_valid = 1'b1;
      data       = memf(base + 32'(4 * w));
      flush_i    = (w == flush_at);
      if (flush_i) flushed = 1'b1;
      step();
      flush_i = 1'b0;
      if (w < 15) begin
        chk("acc_trans", 128'(trans), 128'h0);
        chk("acc_stall", 128'(stall_o), 128'h1);
        // data_valid while trans is idle must be ignored
        data_valid = 1'($urandom);
        data       = $urandom;
        step();
        data_valid = 1'b0;
      end else begin
        data_valid = 1'b0;
        chk("done_stall", 128'(stall_o), 128'h0);
        chk("done_trans", 128'(trans), 128'h0);
        chk("done_valid", 128'(instrs_valid_o), 128'h0);
      end
    end
    if (flushed) begin
      m_clear();
    end else begin
      mv[vic][idx] = 1'b1;
      mt[vic][idx] = a[31:14];
    end
    if (vicv) mrr[idx] = (mrr[idx] + 1) % 2;
  endtask

  typedef struct {
    bit          fetch;
    logic [31:0] a;
    bit          exp_valid;
    int          exp_count;
  } vec_t;

  vec_t        tbl [8];
  bit          m;
  logic [95:0] held;
  logic [31:0] ra;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 32'h0000_1000, 1'b1, 3};
    tbl[1] = '{1'b1, 32'h0000_1004, 1'b1, 3};
    tbl[2] = '{1'b1, 32'h0000_1038, 1'b1, 2};
    tbl[3] = '{1'b0, 32'h0000_1038, 1'b0, 2};
    tbl[4] = '{1'b1, 32'h0000_103C, 1'b1, 1};
    tbl[5] = '{1'b1, 32'h0000_103F, 1'b1, 1};
    tbl[6] = '{1'b1, 32'h0000_1034, 1'b1, 3};
    tbl[7] = '{1'b1, 32'h0000_1002, 1'b1, 3};

    rst = 1'b1; fetch_req_i = 1'b0; flush_i = 1'b0; data_valid = 1'b0;
    addr = '0; data = '0;
    m_reset();
    step(); step();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // cold miss with a 5-cycle data gap at word 8, then hits across the line
    do_fetch(32'h0000_1000, 1'b0, -1, 8, -1, m);
    chk("cold_miss", 128'(m), 128'h1);
    held = '0;
    for (int i = 0; i < 8; i++) begin
      fetch_req_i = tbl[i].fetch;
      addr        = tbl[i].a;
      step();
      fetch_req_i = 1'b0;
      if (tbl[i].fetch) held = exp_words(tbl[i].a, tbl[i].exp_count);
      chk($sformatf("tbl%0d_valid", i), 128'(instrs_valid_o), 128'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_count", i), 128'(instrs_count_o), 128'(tbl[i].exp_count));
      chk($sformatf("tbl%0d_instrs", i), 128'(instrs_o), 128'(held));
      chk($sformatf("tbl%0d_stall", i), 128'(stall_o), 128'h0);
    end

    // three tags into one set: third evicts way 0, then way 1 goes next
    do_fetch(32'h0000_5000, 1'b0, -1, -1, -1, m);
    chk("tagB_miss", 128'(m), 128'h1);
    do_fetch(32'h0000_9000, 1'b0, -1, -1, -1, m);
    chk("tagC_miss", 128'(m), 128'h1);
    do_fetch(32'h0000_1000, 1'b0, -1, -1, -1, m);
    chk("tagA_evicted", 128'(m), 128'h1);
    do_fetch(32'h0000_9008, 1'b0, -1, -1, -1, m);
    chk("tagC_kept", 128'(m), 128'h0);
    do_fetch(32'h0000_5000, 1'b0, -1, -1, -1, m);
    chk("tagB_evicted", 128'(m), 128'h1);

    // flush during a refill drops the line once it completes
    do_fetch(32'h0000_2000, 1'b0, 4, -1, -1, m);
    do_fetch(32'h0000_2000, 1'b0, -1, -1, -1, m);
    chk("flush_refill_miss", 128'(m), 128'h1);
    do_fetch(32'h0000_2010, 1'b0, -1, -1, -1, m);
    chk("refilled_hit", 128'(m), 128'h0);
    // flush together with a request is a miss even on a resident line
    do_fetch(32'h0000_2000, 1'b1, -1, -1, -1, m);
    chk("flush_req_miss", 128'(m), 128'h1);
    do_fetch(32'h0000_2000, 1'b0, -1, -1, -1, m);
    chk("after_flush_req_hit", 128'(m), 128'h0);

    // reset at word 7 aborts the refill and leaves the line invalid
    do_fetch(32'h0000_3000, 1'b0, -1, -1, 7, m);
    do_fetch(32'h0000_3000, 1'b0, -1, -1, -1, m);
    chk("abort_miss", 128'(m), 128'h1);
    do_fetch(32'h0000_2000, 1'b0, -1, -1, -1, m);
    chk("reset_cleared_miss", 128'(m), 128'h1);

    // random traffic over a few colliding tags in two sets
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        flush_i = ($urandom_range(0, 3) == 0);
        step();
        if (flush_i) m_clear();
        flush_i = 1'b0;
        chk("idle_valid", 128'(instrs_valid_o), 128'h0);
        chk("idle_stall", 128'(stall_o), 128'h0);
      end else begin
        ra = (32'($urandom_range(0, 4)) << 14) | (32'($urandom_range(3, 4)) << 6) |
             32'($urandom_range(0, 63));
        do_fetch(ra, $urandom_range(0, 9) == 0,
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
                 -1, m);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
